// File: rtl/reset_manager.sv
// reset_manager: sequences the core and peripheral reset domains.
//
// Reset sources: power-on (rst_n), watchdog level (wdt_reset), external pin
// (ext_rst_n, 2-flop synchronised) and a software request written to SWRST.
// Any active request holds sys_rst_n low for HOLD cycles after the last
// request. periph_rst_n is then released STAGGER_CYCLES later.
//
// Build option: define RESET_MGR_STAGGER_EN to include the STAGGER state.
// Without it, periph_rst_n follows sys_rst_n and ASSERT goes straight to RUN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low power-on reset
//   wdt_reset           watchdog request (active-high, synchronous)
//   ext_rst_n           external reset pin (asynchronous, active-low)
//   sys_rst_n           core-domain reset out (registered, active-low)
//   periph_rst_n        peripheral-domain reset out (registered, active-low)
//   rst_active          high while the sequencer is not in RUN
//   reg_wr/addr/wdata   register write port
//   reg_rdata           combinational read data
//
// Register map: 0x00 CAUSE (W1C, {SW,EXT,WDT,POR}), 0x04 HOLD[15:0],
//               0x08 SWRST (write 0x5A5A5A5A), 0x0C COUNT[7:0] (write clears).
module reset_manager #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned HOLD_DEFAULT   = 16,
  parameter int unsigned STAGGER_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wdt_reset,
  input  logic                  ext_rst_n,
  output logic                  sys_rst_n,
  output logic                  periph_rst_n,
  output logic                  rst_active,
  input  logic                  reg_wr,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam logic [ADDR_WIDTH-1:0] AddrCause = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] AddrHold  = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] AddrSwrst = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] AddrCount = ADDR_WIDTH'(8'h0C);
  localparam logic [DATA_WIDTH-1:0] SwMagic   = DATA_WIDTH'(32'h5A5A_5A5A);
  localparam logic [15:0]           HoldRst   = 16'(HOLD_DEFAULT);

`ifdef RESET_MGR_STAGGER_EN
  typedef enum logic [1:0] {StRun = 2'd0, StAssert = 2'd1, StStagger = 2'd2} state_e;
`else
  typedef enum logic [0:0] {StRun = 1'b0, StAssert = 1'b1} state_e;
`endif

  state_e      r_state, w_state_nxt;
  logic [15:0] r_hold_cnt;
  logic [15:0] r_hold;
  logic [15:0] w_hold_load;
  logic [3:0]  r_cause, w_cause_nxt;
  logic [7:0]  r_count, w_count_nxt;
  logic [1:0]  r_ext_sync;
  logic [1:0]  r_sync_vld;
  logic        r_sys_rst_n;
  logic        w_sys_nxt;

  logic w_req_wdt, w_req_ext, w_req_sw, w_req;
  logic w_wr_cause, w_wr_hold, w_wr_swrst, w_wr_count;
  logic w_count_inc;

  // Register write decode
  assign w_wr_cause = reg_wr && (reg_addr == AddrCause);
  assign w_wr_hold  = reg_wr && (reg_addr == AddrHold);
  assign w_wr_swrst = reg_wr && (reg_addr == AddrSwrst);
  assign w_wr_count = reg_wr && (reg_addr == AddrCount);

  // Request sources
  assign w_req_wdt = wdt_reset;
  // The synchroniser resets to the asserted value; ignore it until two real
  // samples have shifted through so POR alone does not look like an EXT reset.
  assign w_req_ext = r_sync_vld[1] & ~r_ext_sync[1];
  assign w_req_sw  = w_wr_swrst && (reg_wdata == SwMagic);
  assign w_req     = w_req_wdt | w_req_ext | w_req_sw;

  assign w_hold_load = (r_hold == 16'd0) ? 16'd1 : r_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_sync <= 2'b00;
      r_sync_vld <= 2'b00;
    end else begin
      r_ext_sync <= {r_ext_sync[0], ext_rst_n};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StAssert;
    end else begin
      r_state <= w_state_nxt;
    end
  end

`ifdef RESET_MGR_STAGGER_EN
  logic [7:0] r_stag_cnt;
`endif

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_req) begin
      w_state_nxt = StAssert;
    end else begin
      case (r_state)
        StAssert: begin
          if (r_hold_cnt == 16'd1) begin
`ifdef RESET_MGR_STAGGER_EN
            w_state_nxt = StStagger;
`else
            w_state_nxt = StRun;
`endif
          end
        end
`ifdef RESET_MGR_STAGGER_EN
        StStagger: begin
          if (r_stag_cnt == 8'd1) w_state_nxt = StRun;
        end
`endif
        default: ;
      endcase
    end
  end

  // FSM: outputs
`ifdef RESET_MGR_STAGGER_EN
  logic r_periph_rst_n;
  logic w_periph_nxt;

  always_comb begin
    rst_active   = (r_state != StRun);
    w_sys_nxt    = (w_state_nxt != StAssert);
    w_periph_nxt = (w_state_nxt == StRun);
  end
`else
  always_comb begin
    rst_active = (r_state != StRun);
    w_sys_nxt  = (w_state_nxt != StAssert);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sys_rst_n <= 1'b0;
    end else begin
      r_sys_rst_n <= w_sys_nxt;
    end
  end

  assign sys_rst_n = r_sys_rst_n;

`ifdef RESET_MGR_STAGGER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periph_rst_n <= 1'b0;
    end else begin
      r_periph_rst_n <= w_periph_nxt;
    end
  end

  assign periph_rst_n = r_periph_rst_n;

  // Stagger counter loads on the ASSERT->STAGGER hand-off, then counts down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stag_cnt <= 8'(STAGGER_CYCLES);
    end else if (r_state == StAssert && w_state_nxt == StStagger) begin
      r_stag_cnt <= 8'(STAGGER_CYCLES);
    end else if (r_state == StStagger && r_stag_cnt > 8'd1) begin
      r_stag_cnt <= r_stag_cnt - 8'd1;
    end
  end
`else
  assign periph_rst_n = r_sys_rst_n;

  logic w_unused_stagger;
  assign w_unused_stagger = (STAGGER_CYCLES != 0);
`endif

  // Hold counter: any request reloads it, so release is H cycles after the
  // last request regardless of the state it arrived in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= HoldRst;
    end else if (w_req) begin
      r_hold_cnt <= w_hold_load;
    end else if (r_state == StAssert && r_hold_cnt > 16'd1) begin
      r_hold_cnt <= r_hold_cnt - 16'd1;
    end
  end

  // Count entries into ASSERT only, not reloads while already there.
  assign w_count_inc = w_req && (r_state != StAssert);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_count) w_count_nxt = 8'd0;
    if (w_count_inc && w_count_nxt != 8'hFF) w_count_nxt = w_count_nxt + 8'd1;
  end

  // Set wins over a same-cycle W1C of the same bit.
  always_comb begin
    w_cause_nxt = r_cause;
    if (w_wr_cause) w_cause_nxt = r_cause & ~reg_wdata[3:0];
    w_cause_nxt = w_cause_nxt | {w_req_sw, w_req_ext, w_req_wdt, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold  <= HoldRst;
      r_cause <= 4'b0001;
      r_count <= 8'd0;
    end else begin
      if (w_wr_hold) r_hold <= reg_wdata[15:0];
      r_cause <= w_cause_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Read mux; SWRST and unmapped addresses read as zero.
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      AddrCause: reg_rdata = DATA_WIDTH'(r_cause);
      AddrHold:  reg_rdata = DATA_WIDTH'(r_hold);
      AddrCount: reg_rdata = DATA_WIDTH'(r_count);
      default:   reg_rdata = '0;
    endcase
  end

endmodule

// File: doc/reset_manager.md
RESET_MANAGER -- requirements
Module: reset_manager

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register data width.
REQ-003 SHALL have parameter HOLD_DEFAULT, default 16: reset value of HOLD, range 1..65535.
REQ-004 SHALL have parameter STAGGER_CYCLES, default 16: periph release delay, range 1..255.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: power-on reset, asynchronous, active-low.
REQ-007 SHALL have port wdt_reset, input, 1: watchdog reset request, active-high level, synchronous to clk.
REQ-008 SHALL have port ext_rst_n, input, 1: external reset pin, asynchronous, active-low.
REQ-009 SHALL have port sys_rst_n, output, 1: core-domain reset, active-low, registered.
REQ-010 SHALL have port periph_rst_n, output, 1: peripheral-domain reset, active-low, registered.
REQ-011 SHALL have port rst_active, output, 1: high while any sequenced reset is in progress.
REQ-012 SHALL have port reg_wr, input, 1: register write strobe.
REQ-013 SHALL have port reg_addr, input, ADDR_WIDTH: register address.
REQ-014 SHALL have port reg_wdata, input, DATA_WIDTH: write data.
REQ-015 SHALL have port reg_rdata, output, DATA_WIDTH: combinational read data; unmapped addresses read 0.

Function
REQ-016 SHALL provide this register map: 0x00 CAUSE (R/W1C; bit0 POR, bit1 WDT, bit2 EXT, bit3 SW); 0x04 HOLD (R/W, bits[15:0]); 0x08 SWRST (W only); 0x0C COUNT (R, any write clears it; bits[7:0]).
REQ-017 SHALL synchronise ext_rst_n through a 2-flop synchroniser; the EXT request is active while the synchronised value is 0.
REQ-018 SHALL raise a 1-cycle SW request when the write data to SWRST equals 32'h5A5A_5A5A; other data values SHALL be ignored.
REQ-019 SHALL implement an FSM with states RUN, ASSERT and STAGGER.
REQ-020 SHALL, in any state where a request (WDT, EXT or SW) is sampled active, go to ASSERT and load the hold counter from HOLD, treating HOLD=0 as 1.
REQ-021 SHALL, in ASSERT with no request active, decrement the counter and leave ASSERT on the cycle the counter is 1.
REQ-022 SHALL drive sys_rst_n high H cycles after the last cycle a request was sampled active.
REQ-023 SHALL hold periph_rst_n low in STAGGER for STAGGER_CYCLES cycles after sys_rst_n rises, then go to RUN and release periph_rst_n.
REQ-024 SHALL, on a request during STAGGER, return to ASSERT and drive sys_rst_n low again on the next cycle.
REQ-025 SHALL drive rst_active high exactly when the state is not RUN.
REQ-026 SHALL set a CAUSE bit on each cycle its request is active; simultaneous requests SHALL set all corresponding bits.
REQ-027 SHALL give set priority over a same-cycle W1C clear of the same bit.
REQ-028 SHALL increment COUNT on each transition into ASSERT from RUN or STAGGER, not on a reload within ASSERT.
REQ-029 SHALL saturate COUNT at 255.
REQ-030 SHALL apply a HOLD write to the next counter load; the load in progress SHALL be unaffected.
REQ-031 SHALL reset none of its own state from sys_rst_n or periph_rst_n; only rst_n resets the block.

Reset
REQ-032 SHALL, while rst_n is low, force state=ASSERT, counter=HOLD_DEFAULT, HOLD=HOLD_DEFAULT, CAUSE=4'b0001, COUNT=0, synchroniser=0, sys_rst_n=0, periph_rst_n=0, rst_active=1.
REQ-033 SHALL release sys_rst_n HOLD_DEFAULT cycles after rst_n deasserts, with no request active.

Configuration
REQ-034 SHALL, with RESET_MGR_STAGGER_EN defined, implement the STAGGER state per REQ-023.
REQ-035 SHALL, with RESET_MGR_STAGGER_EN undefined, omit the STAGGER state and its counter, drive periph_rst_n identical to sys_rst_n, and go from ASSERT directly to RUN.

Verification
REQ-036 SHALL cover POR with defaults: sys_rst_n rises 16 cycles after rst_n rises; periph_rst_n rises 16 cycles later; CAUSE=0x1; COUNT=0.
REQ-037 SHALL cover a 15-cycle wdt_reset pulse in RUN with HOLD=4: sys_rst_n low from the next cycle until 4 cycles after the pulse ends; CAUSE bit1 set; COUNT increments by 1.
REQ-038 SHALL cover SWRST writes of 0x5A5A5A5A and 0x12345678: only the first starts a reset; CAUSE=0x8 after a prior W1C of 0xF.
REQ-039 SHALL cover ext_rst_n pulled low during STAGGER: sys_rst_n low again within 3 cycles; COUNT increments once; EXT bit set.
REQ-040 SHALL cover W1C of CAUSE bit1 in the same cycle wdt_reset is high: bit1 stays 1.
REQ-041 SHALL cover 300 reset events: COUNT reads 255; a write to COUNT reads back 0.
